// File: rtl/kgp_risc_pkg.sv
// Shared front-end definitions: default widths, reset PC, sequential PC step
// and the fetch-queue entry layout handed to the decoder.
package kgp_risc_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;
  localparam int PC_STEP = 1;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between instruction memory and decoder: flush, occupancy
// count, and a head read straight from the storage registers.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && ((count != FULL_CNT) || pop_ok);
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC register, credit-limited instruction-memory requests,
// stale-response dropping after redirects, and the decoder-side fetch queue.
module instr_fetch_unit import kgp_risc_pkg::*; #(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter int                DATA_W       = DEF_DATA_W,
  parameter int                FQ_DEPTH     = 4,
  parameter int                MAX_INFLIGHT = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [ADDR_W-1:0] dec_pc_next
);

  localparam int IF_W  = $clog2(MAX_INFLIGHT+1);
  localparam int CNT_W = $clog2(FQ_DEPTH+1);
  localparam int SUM_W = ((IF_W > CNT_W) ? IF_W : CNT_W) + 1;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(PC_STEP);
  endfunction

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        rsp_pc;
  logic [IF_W-1:0]          inflight;
  logic [IF_W-1:0]          drop_cnt;
  logic [IF_W-1:0]          live;
  logic [CNT_W-1:0]         q_count;
  logic [SUM_W-1:0]         credit_used;
  logic                     q_empty;
  logic [DATA_W+ADDR_W-1:0] q_head;
  logic                     req_fire;
  logic                     rsp_ok;
  logic                     rsp_drop;
  logic                     q_push;
  logic                     q_pop;

  // Live requests plus queued words may never exceed the queue, so every
  // live response always finds a free slot.
  assign live           = inflight - drop_cnt;
  assign credit_used    = SUM_W'(live) + SUM_W'(q_count);
  assign imem_req_valid = !rst && !redirect_valid
                          && (credit_used < SUM_W'(FQ_DEPTH))
                          && (inflight < IF_W'(MAX_INFLIGHT));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_ok   = imem_rsp_valid && (inflight != '0);
  assign rsp_drop = rsp_ok && (drop_cnt != '0);
  assign q_push   = rsp_ok && !rsp_drop && !redirect_valid;
  assign q_pop    = dec_valid && dec_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + IF_W'(req_fire) - IF_W'(rsp_ok);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // everything still outstanding after this cycle belongs to the old path
        drop_cnt <= inflight - IF_W'(rsp_ok);
      end else begin
        if (req_fire) fetch_pc <= pc_inc(fetch_pc);
        if (q_push)   rsp_pc   <= pc_inc(rsp_pc);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_queue #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign dec_valid   = !q_empty && !rst;
  assign dec_instr   = q_head[ADDR_W +: DATA_W];
  assign dec_pc      = q_head[ADDR_W-1:0];
  assign dec_pc_next = pc_inc(dec_pc);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (inflight == '0)))
        else $error("instr_fetch_unit: memory response with no request in flight");
      assert (drop_cnt <= inflight)
        else $error("instr_fetch_unit: drop count exceeds in-flight count");
    end
  end
`endif

endmodule
